uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART `transmitter` (8N1-style, `din`/`wr_en`/`tx_rdy` handshake) among NREQ byte-stream requesters. It arbitrates round-robin at packet granularity: a winner keeps the transmitter until it delivers a byte flagged `last`. The block sits between the requesting engines (command responder, status reporter, debug dump) and the single transmitter instance. It issues bytes only when the transmitter reports ready.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 1024, lock-watchdog limit in `clk_50m` cycles; used only with UART_TXARB_TIMEOUT_EN
- `clk_50m` input 1: the single clock; all state updates on its rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `req` input NREQ: per-requester byte-valid; held with data until `ack`
- `req_data` input 8*NREQ: byte of requester i at [8i+7:8i]
- `req_last` input NREQ: byte is the final byte of the requester's packet
- `ack` output NREQ: one-hot, one-cycle pulse when a byte is taken
- `owner` output $clog2(NREQ): index of the current or most recent grantee
- `busy` output 1: high while a packet lock is held or a byte is in flight
- `tx_din` output 8: to transmitter `din`
- `tx_wr_en` output 1: to transmitter `wr_en`; one-cycle pulse
- `tx_rdy` input 1: from transmitter `tx_rdy`
- `timeout` output 1: one-cycle pulse on watchdog release; constant 0 without the macro

## Operation
- All outputs are registered. Reset values: `ack`=0, `owner`=NREQ-1, `busy`=0, `tx_din`=8'h00, `tx_wr_en`=0, `timeout`=0. Round-robin pointer resets to NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, LOCKED, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: when `tx_rdy`=1 and `req`≠0, the winner is the first set `req` bit searching upward from pointer+1 (mod NREQ). Latch `owner`=winner, set pointer=winner, then behave as the LOCKED issue cycle. If `tx_rdy`=0 or there is no request, stay in IDLE.
- LOCKED: only `req[owner]` is considered; all other requests are ignored.
  - When `tx_rdy`=1 and `req[owner]`=1: register `tx_din`=owner's byte, `tx_wr_en`=1, `ack[owner]`=1, latch `req_last[owner]` as last_flag, and go to SEND.
- SEND: `tx_wr_en`/`ack` are high for exactly this cycle and clear next cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for `tx_rdy`=0, confirming the transmitter accepted the byte, then go to WAIT_DONE.
- WAIT_DONE: wait for `tx_rdy`=1. Then go to IDLE if last_flag=1 (lock released), else to LOCKED.
- `busy` = (state ≠ IDLE).
- Requester contract:
  - `req`, `req_data`, `req_last` stay stable until `ack`.
  - Dropping `req` before `ack` withdraws the byte with no side effect.
  - After `ack`, the requester may present its next byte immediately. It is not taken before WAIT_DONE→LOCKED.
- Simultaneous events:
  - Several requests in IDLE: exactly one is granted, by rotation.
  - A requester reasserting right after its own `last` has lowest priority in the next arbitration.
- Reset mid-operation: the FSM returns to IDLE and the lock is dropped. A byte already inside the transmitter completes on its own; IDLE does not issue until `tx_rdy`=1.

## Timing
- Issue latency: decision in cycle t (IDLE/LOCKED with `tx_rdy`=1) → `tx_wr_en`/`ack` high in t+1 → `tx_rdy` low in t+2.
- At most one `tx_wr_en` pulse per transmitter IDLE period. `tx_wr_en` is never asserted while `tx_rdy`=0.
- Back-to-back bytes of a locked packet: the next issue decision falls in the cycle after WAIT_DONE sees `tx_rdy`=1, so there is a 2-cycle gap from `tx_rdy` rising to the next `tx_wr_en`.
- Back-to-back packets from different requesters have the same gap: WAIT_DONE→IDLE, then decision, then pulse.

## Configuration
- UART_TXARB_TIMEOUT_EN defined:
  - A counter runs in LOCKED while `req[owner]`=0 and clears on any issue.
  - On reaching TIMEOUT it forces LOCKED→IDLE, releasing the lock, and pulses `timeout` for one cycle.
  - The counter is 0 on reset.
- Not defined: the lock is held indefinitely until `last`, no counter is synthesized, and `timeout` is tied 0.

## Test plan
- Reset, `tx_rdy`=1, `req`=4'b0001 with byte 8'h55 and last=1 → `tx_wr_en` and `ack`=4'b0001 each high exactly one cycle, `tx_din`=8'h55; `busy` returns to 0 after `tx_rdy` rises.
- `req`=4'b1111 held, every byte last=1 → grant order 0,1,2,3,0; `owner` sequence matches.
- Requester 2 sends a 3-byte packet (8'hA1, 8'hA2, 8'hA3 last) while requester 0 requests throughout → all three bytes are sent before any `ack[0]`, then requester 0 is granted.
- `tx_rdy` held 0 for 100 cycles with `req`=4'b0010 → no `tx_wr_en`, no `ack`; issue occurs 1 cycle after `tx_rdy` rises.
- Assert `rst_n`=0 during WAIT_DONE of a locked packet → all outputs at reset values immediately; after release, requester 3 wins first if it is the only request.
- With UART_TXARB_TIMEOUT_EN and TIMEOUT=16: owner drops `req` mid-packet → `timeout` pulses at cycle 16, and another requester is granted next.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bus between the UART transmit arbiter, its requesters and the shared transmitter.
//
// Signals:
//   req       requester byte-valid, one bit per requester
//   req_data  requester bytes, requester i at [8i+7:8i]
//   req_last  byte is the final byte of the requester's packet
//   ack       one-hot pulse when a requester's byte is taken
//   owner     index of the current or most recent grantee
//   busy      packet lock held or byte in flight
//   tx_din    byte to the transmitter
//   tx_wr_en  write strobe to the transmitter
//   tx_rdy    transmitter ready
//   timeout   lock-watchdog release pulse
//
// Modports:
//   slave   the arbiter
//   master  the environment: requesters plus the transmitter's tx_rdy
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned OwnW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   ack;
  logic [OwnW-1:0]   owner;
  logic              busy;
  logic [7:0]        tx_din;
  logic              tx_wr_en;
  logic              tx_rdy;
  logic              timeout;

  modport slave (
    input  req, req_data, req_last, tx_rdy,
    output ack, owner, busy, tx_din, tx_wr_en, timeout
  );

  modport master (
    output req, req_data, req_last, tx_rdy,
    input  ack, owner, busy, tx_din, tx_wr_en, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among NREQ
// byte-stream requesters. A winner keeps the transmitter until it delivers a
// byte flagged last. Bytes are issued only while the transmitter is ready.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   TIMEOUT  lock-watchdog limit in clk_50m cycles (watchdog build only)
//
// Ports:
//   clk_50m  clock, all state on its rising edge
//   rst_n    asynchronous active-low reset
//   bus      uart_tx_arbiter_if.slave: requester and transmitter handshakes
//
// Optional feature: define UART_TXARB_TIMEOUT_EN to add a watchdog that drops a
// lock whose owner stops requesting for TIMEOUT cycles and pulses bus.timeout.
// Without it the lock is held until last and bus.timeout is tied 0.
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic              clk_50m,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned OwnW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_param_check
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLocked,
    StSend,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e          state_q, state_d;
  // owner doubles as the round-robin pointer: the last grantee has lowest priority
  logic [OwnW-1:0] owner_q, owner_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      din_q, din_d;
  logic            wr_en_q, wr_en_d;
  logic            last_q, last_d;
  logic            busy_q;

  logic            issue;
  logic [OwnW-1:0] issue_idx;
  logic            wd_fire;

  // Round-robin search upward from owner+1, wrapping at NREQ
  logic [OwnW-1:0] cand;
  logic [OwnW-1:0] rr_winner;
  logic            rr_found;

  always_comb begin
    cand      = '0;
    rr_winner = owner_q;
    rr_found  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OwnW'((32'(owner_q) + k) % NREQ);
      if (!rr_found && bus.req[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ack_d     = '0;
    din_d     = din_q;
    wr_en_d   = 1'b0;
    last_d    = last_q;
    issue     = 1'b0;
    issue_idx = owner_q;

    unique case (state_q)
      StIdle: begin
        if (bus.tx_rdy && rr_found) begin
          issue     = 1'b1;
          issue_idx = rr_winner;
        end
      end
      StLocked: begin
        if (bus.tx_rdy && bus.req[owner_q]) begin
          issue = 1'b1;
        end else if (wd_fire) begin
          state_d = StIdle;
        end
      end
      StSend: begin
        state_d = StWaitBusy;
      end
      // tx_rdy low confirms the transmitter took the byte
      StWaitBusy: begin
        if (!bus.tx_rdy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (bus.tx_rdy) state_d = last_q ? StIdle : StLocked;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (issue) begin
      owner_d          = issue_idx;
      din_d            = bus.req_data[{issue_idx, 3'b000} +: 8];
      wr_en_d          = 1'b1;
      ack_d[issue_idx] = 1'b1;
      last_d           = bus.req_last[issue_idx];
      state_d          = StSend;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= OwnW'(NREQ - 1);
      ack_q   <= '0;
      din_q   <= 8'h00;
      wr_en_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      din_q   <= din_d;
      wr_en_q <= wr_en_d;
      last_q  <= last_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign bus.ack      = ack_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;
  assign bus.tx_din   = din_q;
  assign bus.tx_wr_en = wr_en_q;

`ifdef UART_TXARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q;

  // Counts locked cycles in which the owner is not requesting
  assign wd_fire = (state_q == StLocked) && !bus.req[owner_q] &&
                   (wd_cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (issue || wd_fire) begin
      wd_cnt_d = '0;
    end else if ((state_q == StLocked) && !bus.req[owner_q]) begin
      wd_cnt_d = wd_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= wd_fire;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int unsigned NREQ = 4;
`ifdef UART_TXARB_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 16;
`else
  localparam int unsigned TIMEOUT = 1024;
`endif

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_50m = ~clk_50m;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_50m(clk_50m),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int tests     = 0;
  int fails     = 0;
  int proto_err = 0;
  int wr_count  = 0;
  int busy_len  = 4;
  bit rand_len  = 1'b0;
  bit hold      = 1'b0;

  // Transmitter model: takes a byte on tx_wr_en, stays busy busy_len cycles.
  // hold forces tx_rdy low while idle.
  initial begin : xmit_model
    int cnt;
    cnt = 0;
    bus.tx_rdy = 1'b1;
    forever begin
      @(negedge clk_50m);
      if (bus.tx_wr_en === 1'b1) begin
        if (bus.tx_rdy !== 1'b1) proto_err++;
        wr_count++;
        cnt = rand_len ? int'($urandom_range(6, 2)) : busy_len;
      end else if (cnt > 0) begin
        cnt--;
      end
      bus.tx_rdy = (cnt == 0) && !hold;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int i, input bit v, input logic [7:0] d, input bit l);
    bus.req[i]            = v;
    bus.req_data[8*i +: 8] = d;
    bus.req_last[i]       = l;
  endtask

  task automatic do_reset();
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input string tag, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.ack !== '0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ack"},     32'(bus.ack),      32'd0);
    chk({tag, " owner"},   32'(bus.owner),    NREQ - 1);
    chk({tag, " busy"},    32'(bus.busy),     32'd0);
    chk({tag, " tx_din"},  32'(bus.tx_din),   32'h00);
    chk({tag, " wr_en"},   32'(bus.tx_wr_en), 32'd0);
    chk({tag, " timeout"}, 32'(bus.timeout),  32'd0);
  endtask

  int          rem [NREQ];
  logic [7:0]  cur [NREQ];
  int          w0, cnt_bad, k, n_txn, to_seen, ptr, lock, win, pend;
  int          exp_i [4];
  logic [7:0]  exp_b [4];

  initial begin : main
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;

    // Reset values, during and just after reset
    step();
    chk_reset_vals("in reset");
    rst_n = 1'b1;
    step();
    chk_reset_vals("after reset");

    // Single one-byte packet from requester 0
    w0 = wr_count;
    present(0, 1'b1, 8'h55, 1'b1);
    wait_ack("single ack seen", 20);
    chk("single ack", 32'(bus.ack), 32'b0001);
    chk("single din", 32'(bus.tx_din), 32'h55);
    chk("single wr_en", 32'(bus.tx_wr_en), 32'd1);
    chk("single owner", 32'(bus.owner), 32'd0);
    present(0, 1'b0, 8'h00, 1'b0);
    step();
    chk("single ack clears", 32'(bus.ack), 32'd0);
    chk("single wr_en clears", 32'(bus.tx_wr_en), 32'd0);
    chk("single busy", 32'(bus.busy), 32'd1);
    wait_idle("single idle");
    chk("single tx_rdy at idle", 32'(bus.tx_rdy), 32'd1);
    chk("single one pulse", 32'(wr_count - w0), 32'd1);

    // All four requesting, one-byte packets: rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) present(i, 1'b1, 8'(8'h10 + i), 1'b1);
    for (int n = 0; n < 5; n++) begin
      wait_ack("rr ack seen", 40);
      chk("rr ack", 32'(bus.ack), 32'(1) << (n % NREQ));
      chk("rr owner", 32'(bus.owner), 32'(n % NREQ));
      chk("rr din", 32'(bus.tx_din), 32'h10 + 32'(n % NREQ));
      step();
    end
    bus.req = '0;
    wait_idle("rr idle");

    // Locked 3-byte packet from requester 2 while requester 0 waits
    do_reset();
    exp_i = '{2, 2, 2, 0};
    exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'h0F};
    present(2, 1'b1, 8'hA1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      wait_ack("lock ack seen", 40);
      chk("lock ack", 32'(bus.ack), 32'(1) << exp_i[n]);
      chk("lock din", 32'(bus.tx_din), 32'(exp_b[n]));
      if (n == 0) present(0, 1'b1, 8'h0F, 1'b1);
      if (n < 2) present(2, 1'b1, exp_b[n+1], n == 1);
      if (n == 2) present(2, 1'b0, 8'h00, 1'b0);
      if (n == 3) present(0, 1'b0, 8'h00, 1'b0);
      step();
    end
    wait_idle("lock idle");

    // Transmitter not ready for 100 cycles
    hold = 1'b1;
    step();
    step();
    w0 = wr_count;
    cnt_bad = 0;
    present(1, 1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.ack !== '0 || bus.tx_wr_en !== 1'b0) cnt_bad++;
    end
    chk("hold no ack/wr_en", 32'(cnt_bad), 32'd0);
    chk("hold no pulses", 32'(wr_count - w0), 32'd0);
    hold = 1'b0;
    step();
    chk("hold release wr_en", 32'(bus.tx_wr_en), 32'd1);
    chk("hold release ack", 32'(bus.ack), 32'b0010);
    chk("hold release din", 32'(bus.tx_din), 32'h77);
    present(1, 1'b0, 8'h00, 1'b0);
    wait_idle("hold idle");

    // Reset while waiting for a locked packet's byte to finish
    busy_len = 12;
    present(1, 1'b1, 8'hC1, 1'b0);
    wait_ack("mid-reset ack seen", 40);
    chk("mid-reset first ack", 32'(bus.ack), 32'b0010);
    present(1, 1'b1, 8'hC2, 1'b1);
    repeat (5) step();
    chk("mid-reset busy before", 32'(bus.busy), 32'd1);
    chk("mid-reset tx busy", 32'(bus.tx_rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid-reset");
    present(1, 1'b0, 8'h00, 1'b0);
    present(3, 1'b1, 8'h3C, 1'b1);
    step();
    rst_n = 1'b1;
    wait_ack("mid-reset req3 seen", 40);
    chk("mid-reset req3 ack", 32'(bus.ack), 32'b1000);
    chk("mid-reset req3 din", 32'(bus.tx_din), 32'h3C);
    present(3, 1'b0, 8'h00, 1'b0);
    busy_len = 4;
    wait_idle("mid-reset idle");

`ifdef UART_TXARB_TIMEOUT_EN
    // Owner abandons its packet; watchdog frees the lock
    do_reset();
    present(1, 1'b1, 8'hD1, 1'b0);
    wait_ack("wd first ack seen", 40);
    present(1, 1'b0, 8'h00, 1'b0);
    present(2, 1'b1, 8'hE2, 1'b1);
    step();
    for (int i = 0; i < 40 && bus.tx_rdy !== 1'b1; i++) step();
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      k++;
      if (bus.timeout === 1'b1) break;
    end
    chk("wd timeout cycle", 32'(k), TIMEOUT);
    chk("wd busy dropped", 32'(bus.busy), 32'd0);
    step();
    chk("wd timeout one cycle", 32'(bus.timeout), 32'd0);
    chk("wd next grant", 32'(bus.ack), 32'b0100);
    present(2, 1'b0, 8'h00, 1'b0);
    wait_idle("wd idle");
`endif

    // Randomized traffic against a packet-level round-robin model
    do_reset();
    rand_len = 1'b1;
    ptr = NREQ - 1;
    lock = -1;
    n_txn = 0;
    to_seen = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      rem[i] = 0;
      cur[i] = 8'h00;
    end
    for (int cyc = 0; cyc < 6000; cyc++) begin
      step();
      if (bus.timeout === 1'b1) to_seen++;
      if (bus.ack !== '0) begin
        win = -1;
        if (lock >= 0) begin
          win = lock;
        end else begin
          for (int j = 1; j <= int'(NREQ); j++) begin
            if (win < 0 && bus.req[(ptr + j) % NREQ]) win = (ptr + j) % NREQ;
          end
        end
        n_txn++;
        if (win < 0) begin
          chk("rand unexpected ack", 32'(bus.ack), 32'd0);
        end else begin
          chk("rand ack", 32'(bus.ack), 32'(1) << win);
          chk("rand din", 32'(bus.tx_din), 32'(cur[win]));
          chk("rand owner", 32'(bus.owner), 32'(win));
          ptr = win;
          lock = (rem[win] == 1) ? -1 : win;
          rem[win]--;
          cur[win] = 8'($urandom);
          present(win, rem[win] > 0, cur[win], rem[win] == 1);
        end
      end
      if (cyc < 3000) begin
        for (int i = 0; i < int'(NREQ); i++) begin
          if (rem[i] == 0 && $urandom_range(15, 0) == 0) begin
            rem[i] = int'($urandom_range(3, 1));
            cur[i] = 8'($urandom);
            present(i, 1'b1, cur[i], rem[i] == 1);
          end
        end
      end else begin
        pend = 0;
        for (int i = 0; i < int'(NREQ); i++) pend += rem[i];
        if (pend == 0 && bus.busy === 1'b0) break;
      end
    end
    pend = 0;
    for (int i = 0; i < int'(NREQ); i++) pend += rem[i];
    chk("rand drained", 32'(pend), 32'd0);
    chk("rand enough traffic", 32'(n_txn > 50), 32'd1);
`ifndef UART_TXARB_TIMEOUT_EN
    chk("timeout tied low", 32'(to_seen), 32'd0);
`endif
    chk("no wr_en while not ready", 32'(proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
